seq_adder_arb: RTL and testbench
================================

SEQ_ADDER_ARB -- requirements
Module: seq_adder_arb

Interface
REQ-001 Parameter: WIDTH, 64, operand/sum width; SHALL be an integer multiple of SLICE.
REQ-002 Parameter: SLICE, 8, bits added per cycle by the single shared adder slice; NSLICE = WIDTH/SLICE.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0, req1  input  1 each  level request from requester 0/1; held until its grant.
REQ-007 a0, b0, a1, b1  input  WIDTH each  operands of requester 0/1, sampled only on the grant edge.
REQ-008 cin0, cin1  input  1 each  carry-in of requester 0/1, sampled with operands.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-010 busy  output  1  high while an operation is in RUN or DONE.
REQ-011 sum  output  WIDTH  result, (a + b + cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of sum MSB.
REQ-013 valid  output  1  one-cycle pulse: sum/cout/owner hold a new result.
REQ-014 owner  output  1  requester id of the current sum/cout.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; one addition at a time through one SLICE-bit adder with a registered carry.
REQ-016 IDLE: no request -> stay; else grant per REQ-021, latch operands and carry-in, clear slice counter, pulse matching gnt, go RUN.
REQ-017 RUN: each cycle k (0..NSLICE-1) SHALL write sum bits [k*SLICE +: SLICE] = a slice + b slice + carry, update carry, increment k; at k = NSLICE-1 go DONE.
REQ-018 DONE: valid=1 for exactly one cycle, cout = final carry, owner = granted id; next state IDLE.
REQ-019 Latency: grant edge cycle T; RUN cycles T+1..T+NSLICE; valid at T+NSLICE+1 (T+9 for defaults); next grant no earlier than T+NSLICE+2.
REQ-020 gnt0/gnt1 SHALL only pulse in IDLE, never together, never while busy; requests during busy are neither granted nor lost (granted later if still held).
REQ-021 Arbitration round-robin: single request wins; on a tie the requester not granted last wins; last-grant register resets to 1 so requester 0 wins the first tie.
REQ-022 Dropping req before its grant SHALL withdraw it with no side effect.
REQ-023 sum, cout, owner SHALL hold their values between DONE cycles except that sum slices update in RUN; consumers SHALL sample only on valid.
REQ-024 Operand changes after grant SHALL NOT affect the result in progress.
REQ-025 Carry SHALL propagate across slice boundaries exactly as a WIDTH-bit ripple addition.

Reset
REQ-026 rst SHALL force IDLE, counter 0, carry 0, last-grant 1, sum 0, cout 0, owner 0, valid 0, busy 0, gnt0/gnt1 0.
REQ-027 rst during RUN or DONE SHALL abandon the operation: no valid pulse, no grant on that edge, outputs as REQ-026 the next cycle.
REQ-028 rst SHALL take priority over any simultaneous request.

Verification
REQ-029 req0, a0=0xFFFF_FFFF_FFFF_FFFF, b0=1, cin0=0 -> gnt0 at T, valid at T+9, sum=0, cout=1, owner=0.
REQ-030 req0 and req1 together after reset (a0=3,b0=4; a1=10,b1=20,cin1=1) -> gnt0 at T, valid sum=7 owner=0 at T+9; gnt1 at T+10, valid sum=31 owner=1 at T+19.
REQ-031 Both held continuously -> grants alternate 0,1,0,1; four valid pulses spaced 10 cycles.
REQ-032 a0=0x0000_0000_0000_00FF, b0=1, cin0=0 -> sum=0x100, cout=0 (slice-boundary carry); a0=0x7FFF_FFFF_FFFF_FFFF, b0=1 -> sum=0x8000_0000_0000_0000, cout=0.
REQ-033 rst asserted at T+4 of an operation -> busy=0, sum=0 next cycle, no valid ever for that operation; new req0 then completes normally.
REQ-034 req1 asserted at T+3 while busy, a0 changed at T+2 -> no gnt1 until T+10; requester 0 result uses operands captured at T.

Source files
------------

// File: rtl/seq_adder_arb_if.sv
// seq_adder_arb_if: request/operand/result bundle between two requesters and the shared adder
interface seq_adder_arb_if #(parameter int WIDTH = 64);
  logic req0, req1, cin0, cin1, gnt0, gnt1, busy, cout, valid, owner;
  logic [WIDTH-1:0] a0, b0, a1, b1, sum;
  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input gnt0, gnt1, busy, sum, cout, valid, owner
  );
  modport slave (
    input req0, req1, a0, b0, a1, b1, cin0, cin1,
    output gnt0, gnt1, busy, sum, cout, valid, owner
  );
endinterface

// File: rtl/seq_adder_arb.sv
// seq_adder_arb: round-robin arbitrated WIDTH-bit adder using one SLICE-bit adder over NSLICE cycles
module seq_adder_arb #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst,
  seq_adder_arb_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [KW-1:0] k;
  logic [SLICE:0] slice_sum;
  logic carry, last, id, pick1, grant, last_k;
  // on a tie the requester not granted last wins
  assign pick1 = bus.req1 & (~bus.req0 | ~last);
  assign grant = (bus.req0 | bus.req1) & ~rst;
  assign last_k = k == KW'(NSLICE - 1);
  assign slice_sum = {1'b0, a_r[k*SLICE +: SLICE]} + {1'b0, b_r[k*SLICE +: SLICE]} + {{SLICE{1'b0}}, carry};
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    bus.valid = 1'b0;
    case (state)
      IDLE: begin
        state_nx = grant ? RUN : IDLE;
        bus.gnt0 = grant & ~pick1;
        bus.gnt1 = grant & pick1;
      end
      RUN: state_nx = last_k ? DONE : RUN;
      DONE: begin
        state_nx = IDLE;
        bus.valid = ~rst;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      carry <= 1'b0;
      last <= 1'b1;
      id <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.owner <= 1'b0;
    end else begin
      if (state == IDLE && grant) begin
        a_r <= pick1 ? bus.a1 : bus.a0;
        b_r <= pick1 ? bus.b1 : bus.b0;
        carry <= pick1 ? bus.cin1 : bus.cin0;
        k <= '0;
        id <= pick1;
        last <= pick1;
      end
      if (state == RUN) begin
        bus.sum[k*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
        carry <= slice_sum[SLICE];
        k <= k + 1'b1;
        if (last_k) begin
          bus.cout <= slice_sum[SLICE];
          bus.owner <= id;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_adder_arb.sv
// tb_seq_adder_arb: directed and random requests checked against a transaction-level arbiter/adder model
module tb_seq_adder_arb;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, errors = 0, nvalid = 0, n0;
  int phase = 0;
  bit last_m = 1'b1, prev_rst = 1'b0, armed = 1'b0;
  typedef struct {logic [63:0] s; logic c; logic o;} res_t;
  res_t q[$];
  seq_adder_arb_if #(.WIDTH(64)) bus();
  seq_adder_arb #(.WIDTH(64), .SLICE(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic op0(input logic [63:0] a, input logic [63:0] b, input logic c);
    bus.a0 = a;
    bus.b0 = b;
    bus.cin0 = c;
    bus.req0 = 1'b1;
    step(1);
    bus.req0 = 1'b0;
  endtask
  // reference: one addition occupies the adder for grant + 9 cycles; result is plain 65-bit arithmetic
  always @(negedge clk) begin
    logic pick, gx;
    logic [64:0] r;
    res_t e;
    pick = (bus.req0 & bus.req1) ? ~last_m : bus.req1;
    gx = !rst && phase == 0 && (bus.req0 || bus.req1);
    if (armed) begin
      if (prev_rst) begin
        chk("rst_sum", 65'(bus.sum), 65'(0));
        chk("rst_cout_owner", 65'({bus.cout, bus.owner}), 65'(0));
      end
      chk("busy", 65'(bus.busy), 65'(phase != 0));
      chk("gnt0", 65'(bus.gnt0), 65'(gx && !pick));
      chk("gnt1", 65'(bus.gnt1), 65'(gx && pick));
      chk("valid", 65'(bus.valid), 65'(!rst && phase == 9));
      if (bus.valid && q.size() > 0) begin
        e = q.pop_front();
        chk("sum", 65'(bus.sum), 65'(e.s));
        chk("cout", 65'(bus.cout), 65'(e.c));
        chk("owner", 65'(bus.owner), 65'(e.o));
        nvalid++;
      end
    end
    if (rst) begin
      phase = 0;
      last_m = 1'b1;
      q.delete();
    end else if (phase == 9) phase = 0;
    else if (phase > 0) phase++;
    else if (gx) begin
      r = pick ? {1'b0, bus.a1} + {1'b0, bus.b1} + 65'(bus.cin1)
               : {1'b0, bus.a0} + {1'b0, bus.b0} + 65'(bus.cin0);
      e.s = r[63:0];
      e.c = r[64];
      e.o = pick;
      q.push_back(e);
      last_m = pick;
      phase = 1;
    end
    prev_rst = rst;
  end
  initial begin
    rst = 1'b1;
    {bus.req0, bus.req1, bus.cin0, bus.cin1} = '0;
    {bus.a0, bus.b0, bus.a1, bus.b1} = '0;
    step(3);
    bus.req0 = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    chk("reset_gnt0", 65'(bus.gnt0), 65'(0));
    chk("reset_busy", 65'(bus.busy), 65'(0));
    chk("reset_sum", 65'(bus.sum), 65'(0));
    step(1);
    bus.req0 = 1'b0;
    rst = 1'b0;
    step(2);
    op0(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step(12);
    op0(64'h0000_0000_0000_00FF, 64'd1, 1'b0);
    step(12);
    op0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step(12);
    bus.a0 = 64'd3;
    bus.b0 = 64'd4;
    bus.cin0 = 1'b0;
    bus.a1 = 64'd10;
    bus.b1 = 64'd20;
    bus.cin1 = 1'b1;
    {bus.req0, bus.req1} = 2'b11;
    step(1);
    bus.req0 = 1'b0;
    step(10);
    bus.req1 = 1'b0;
    step(12);
    n0 = nvalid;
    {bus.req0, bus.req1} = 2'b11;
    step(40);
    {bus.req0, bus.req1} = 2'b00;
    step(12);
    chk("alternating_valids", 65'(nvalid - n0), 65'(4));
    op0(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    op0(64'hDEAD_BEEF_0000_0001, 64'h2, 1'b1);
    step(12);
    op0(64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0);
    step(1);
    bus.a0 = 64'hFFFF;
    step(1);
    bus.req1 = 1'b1;
    bus.a1 = 64'd5;
    bus.b1 = 64'd6;
    step(10);
    bus.req1 = 1'b0;
    step(12);
    op0(64'd100, 64'd200, 1'b0);
    step(2);
    bus.req1 = 1'b1;
    step(3);
    bus.req1 = 1'b0;
    step(12);
    for (int i = 0; i < 40; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.a0 = {$urandom, $urandom};
      bus.b0 = {$urandom, $urandom};
      bus.a1 = {$urandom, $urandom};
      bus.b1 = {$urandom, $urandom};
      bus.cin0 = 1'($urandom_range(0, 1));
      bus.cin1 = 1'($urandom_range(0, 1));
      rst = $urandom_range(0, 15) == 0;
      step(1);
      rst = 1'b0;
      step($urandom_range(0, 10));
    end
    {bus.req0, bus.req1} = 2'b00;
    step(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
